// File: rtl/xif_timer.sv
// rtl/xif_timer.sv - memory-mapped periodic/one-shot timer with prescaler and level irq on the xif split bus
module xif_timer #(
    parameter logic [31:0] BASE_ADDR    = 32'h80001000,
    parameter logic [31:0] RESET_PERIOD = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_PERIOD = 3'd1;
    localparam logic [2:0] IDX_COUNT  = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_PRESC  = 3'd4;

    logic [2:0]  ctrl_q;
    logic [31:0] period_q;
    logic [31:0] count_q;
    logic        pend_q;
    logic [31:0] presc_q;
    logic [31:0] presc_cnt_q;
    logic        resp_q;
    logic [31:0] rdata_q;
    logic        irq_q;

    logic        hit;
    logic        wr;
    logic        rd;
    logic [2:0]  idx;
    logic        tick;
    logic        match;
    logic [31:0] count_upd;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign hit         = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
    assign bus_ack_o   = bus_req_i & hit;
    assign wr          = bus_ack_o & bus_we_i;
    assign rd          = bus_ack_o & ~bus_we_i;
    assign idx         = bus_addr_bi[4:2];
    assign unused_addr = ^bus_addr_bi[1:0];

    assign tick      = ctrl_q[0] && (presc_cnt_q == presc_q);
    assign match     = tick && (count_q == period_q);
    assign count_upd = !tick ? count_q : (match ? 32'd0 : count_q + 32'd1);

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rd_val = 32'd0;
        case (idx)
            IDX_CTRL:   rd_val = {29'd0, ctrl_q};
            IDX_PERIOD: rd_val = period_q;
            IDX_COUNT:  rd_val = count_q;
            IDX_STATUS: rd_val = {31'd0, pend_q};
            IDX_PRESC:  rd_val = presc_q;
            default:    rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ctrl_q      <= 3'd0;
            period_q    <= RESET_PERIOD;
            count_q     <= 32'd0;
            pend_q      <= 1'b0;
            presc_q     <= 32'd0;
            presc_cnt_q <= 32'd0;
            resp_q      <= 1'b0;
            rdata_q     <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            // Reads capture register state before this edge's counter update.
            resp_q  <= rd;
            rdata_q <= rd ? rd_val : 32'd0;
            irq_q   <= pend_q & ctrl_q[1];

            if (ctrl_q[0]) presc_cnt_q <= tick ? 32'd0 : presc_cnt_q + 32'd1;
            count_q <= count_upd;
            if (match) begin
                pend_q <= 1'b1;
                if (ctrl_q[2]) ctrl_q[0] <= 1'b0;
            end

            // Bus writes are applied last so they override same-edge counter effects.
            if (wr) begin
                case (idx)
                    IDX_CTRL: if (bus_be_bi[0]) begin
                        ctrl_q <= bus_wdata_bi[2:0];
                        if (!bus_wdata_bi[0]) presc_cnt_q <= 32'd0;
                    end
                    IDX_PERIOD: period_q <= merge(period_q, bus_wdata_bi, bus_be_bi);
                    IDX_COUNT:  count_q  <= merge(count_upd, bus_wdata_bi, bus_be_bi);
                    IDX_STATUS: if (bus_be_bi[0] && bus_wdata_bi[0] && !match) pend_q <= 1'b0;
                    IDX_PRESC:  presc_q  <= merge(presc_q, bus_wdata_bi, bus_be_bi);
                    default: ;
                endcase
            end
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign irq_o        = irq_q;

endmodule

// File: doc/xif_timer.md
Name: xif_timer

Overview:
- Memory-mapped 32-bit timer/interrupt peripheral on the tile's external split bus (xif, MemSplit32 protocol).
- Sits directly downstream of the tile's xif port, alongside the GPIO CSRs.
- Generates a level interrupt that feeds one bit of the tile's irq_debounced_bi vector.
- Provides a free-running/periodic/one-shot counter with a prescaler, readable and writable over the bus.

Parameters:
- BASE_ADDR, 32'h80001000, base of the 32-byte register window; must be 32-byte aligned.
- RESET_PERIOD, 32'hFFFFFFFF, reset value of PERIOD.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rstn_i  in  1  synchronous active-low reset.
- bus_req_i  in  1  request valid.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_bi  in  32  byte address.
- bus_be_bi  in  4  byte enables; writes only.
- bus_wdata_bi  in  32  write data.
- bus_ack_o  out  1  request accepted.
- bus_resp_o  out  1  read data valid.
- bus_rdata_bo  out  32  read data.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: one synchronous active-low reset; when rstn_i=0 at a clock edge:
  - all registers, the prescaler counter and bus_resp_o go to 0, except PERIOD, which goes to RESET_PERIOD.
  - irq_o=0.
  - Reset mid-operation discards any pending read response.
- Decode: hit = bus_addr_bi[31:5] == BASE_ADDR[31:5]; register index = bus_addr_bi[4:2]; bits [1:0] are ignored.
- Handshake:
  - bus_ack_o = bus_req_i & hit, combinational; the block never stalls.
  - Non-hit requests get no ack and no resp.
- Write: a write takes effect at the edge on which it is acked. Each byte lane is written only if its bus_be_bi bit is set.
- Read:
  - bus_resp_o is asserted exactly 1 cycle after an acked read, for 1 cycle.
  - bus_rdata_bo holds the register value sampled at accept time while bus_resp_o=1, and 0 otherwise.
  - Back-to-back reads give back-to-back responses.
  - Acked writes never produce a resp.
- Register map (byte offsets):
  - 0x00 CTRL: [0] EN, [1] IRQ_EN, [2] ONESHOT; other bits read 0.
  - 0x04 PERIOD: R/W.
  - 0x08 COUNT: R/W.
  - 0x0C STATUS: [0] PEND; write 1 to clear, write 0 has no effect.
  - 0x10 PRESC: R/W; a tick occurs every PRESC+1 cycles.
  - 0x14–0x1C: reserved; read 0 with resp, writes ignored.
- Counting:
  - When EN=1, a prescaler counter runs 0..PRESC and emits a tick when it equals PRESC, then returns to 0.
  - On a tick: if COUNT==PERIOD, then COUNT<=0 and PEND<=1, and EN<=0 if ONESHOT=1. Otherwise COUNT<=COUNT+1, mod 2^32.
  - EN=0 freezes COUNT and the prescaler; the prescaler is cleared when EN is written 0.
  - PERIOD=0: a match occurs on every tick.
  - PERIOD written below the current COUNT: COUNT keeps incrementing, wraps 0xFFFFFFFF→0, and matches on the next pass.
- irq_o = PEND & IRQ_EN, registered; it follows register state with 1 cycle latency.
- Simultaneous events:
  - COUNT write coincides with a tick: the bus write wins, and the prescaler counter is cleared.
  - PEND set (match) coincides with a write-1-to-clear: set wins, PEND stays 1.
  - CTRL write coincides with a one-shot match: the bus-written EN value wins.
  - A read on the same edge as a match returns pre-update values.

Test Plan:
- Reset then read all of 0x00–0x1C → resp each 1 cycle after ack. Data: 0, FFFFFFFF, 0, 0, 0, 0, 0, 0. irq_o=0.
- PERIOD=3, PRESC=0, CTRL=3 → COUNT sequence 0,1,2,3,0. PEND=1 on the cycle after COUNT=3. irq_o rises 1 cycle later. Write STATUS=1 → irq_o falls 2 cycles after the write.
- PRESC=4, PERIOD=1, CTRL=5 (one-shot) → COUNT advances every 5 cycles. After the match, CTRL reads 4 (EN=0), COUNT stays 0, and PEND=1.
- Write COUNT=0xFFFFFFF0 with PERIOD=5 running → COUNT wraps through 0xFFFFFFFF→0 and matches at 5. Write COUNT with be=4'b0010 and wdata=0x0000AB00 → only byte 1 changes.
- Force a match and a STATUS clear on the same edge → PEND reads 1.
- Issue requests to address 0x80000000 (outside window) → bus_ack_o=0, no resp. Then 3 back-to-back reads of PERIOD → 3 consecutive resp cycles. Then assert rstn_i=0 while a read response is pending → resp suppressed, all outputs 0.
